// File: rtl/load_store_unit.sv
// Load/store unit: aligns core byte/half/word accesses onto a 32-bit word memory.
// Define LSU_MISALIGN_SPLIT_EN to split word-crossing accesses instead of faulting them.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_read_address,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_write_mask,
    output logic        mem_write_enable
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, RESP} state_t;

    state_t      r_state;
    logic        r_phase;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_off;
    logic        r_split;
    logic [31:0] r_lo_word;
    logic [31:0] r_wdata_hi;
    logic [31:0] r_mask_hi;

    logic [1:0]  w_off;
    logic [31:0] w_size_mask;
    logic [63:0] w_data64;
    logic [63:0] w_mask64;
    logic        w_fault;
    logic        w_split;

    // Pair is {upper word, lower word}; the access starts at byte off of the lower word.
    function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = 32'(pair >> {off, 3'b000});
        case (size)
            2'd0:    return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    assign w_off = req_addr[1:0];

    always_comb begin
        w_size_mask = 32'h0000_0000;
        case (req_size)
            2'd0:    w_size_mask = 32'h0000_00FF;
            2'd1:    w_size_mask = 32'h0000_FFFF;
            2'd2:    w_size_mask = 32'hFFFF_FFFF;
            default: w_size_mask = 32'h0000_0000;
        endcase
    end

    assign w_data64 = {32'd0, req_wdata & w_size_mask} << {w_off, 3'b000};
    assign w_mask64 = {32'd0, w_size_mask} << {w_off, 3'b000};

`ifdef LSU_MISALIGN_SPLIT_EN
    assign w_fault = (req_size == 2'd3);
    assign w_split = |w_mask64[63:32];
`else
    assign w_fault = (req_size == 2'd3) || (req_size == 2'd1 && w_off[0]) ||
                     (req_size == 2'd2 && w_off != 2'd0);
    assign w_split = 1'b0;
`endif

    assign req_ready = (r_state == IDLE) && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state           <= IDLE;
            r_phase           <= 1'b0;
            r_size            <= 2'd0;
            r_unsigned        <= 1'b0;
            r_off             <= 2'd0;
            r_split           <= 1'b0;
            r_lo_word         <= 32'd0;
            r_wdata_hi        <= 32'd0;
            r_mask_hi         <= 32'd0;
            resp_valid        <= 1'b0;
            resp_rdata        <= 32'd0;
            resp_fault        <= 1'b0;
            mem_read_address  <= 32'd0;
            mem_write_address <= 32'd0;
            mem_write_data    <= 32'd0;
            mem_write_mask    <= 32'd0;
            mem_write_enable  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_off      <= w_off;
                        r_split    <= w_split;
                        r_phase    <= 1'b0;
                        if (w_fault) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else if (req_write) begin
                            r_state           <= WR1;
                            mem_write_address <= {req_addr[31:2], 2'b00};
                            mem_write_data    <= w_data64[31:0];
                            mem_write_mask    <= w_mask64[31:0];
                            mem_write_enable  <= 1'b1;
                            r_wdata_hi        <= w_data64[63:32];
                            r_mask_hi         <= w_mask64[63:32];
                        end else begin
                            r_state          <= RD1;
                            mem_read_address <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                // Phase 0 waits for memory to sample the address; phase 1 sees its data.
                RD1: begin
                    if (!r_phase) begin
                        if (r_split) begin
                            mem_read_address <= mem_read_address + 32'd4;
                            r_state          <= RD2;
                        end else begin
                            r_phase <= 1'b1;
                        end
                    end else begin
                        resp_rdata <= extend_load({32'd0, mem_read_data}, r_off, r_size, r_unsigned);
                        resp_fault <= 1'b0;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                RD2: begin
                    if (!r_phase) begin
                        r_lo_word <= mem_read_data;
                        r_phase   <= 1'b1;
                    end else begin
                        resp_rdata <= extend_load({mem_read_data, r_lo_word}, r_off, r_size, r_unsigned);
                        resp_fault <= 1'b0;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end
                end
                WR1: begin
                    if (r_split) begin
                        mem_write_address <= mem_write_address + 32'd4;
                        mem_write_data    <= r_wdata_hi;
                        mem_write_mask    <= r_mask_hi;
                        r_state           <= WR2;
                    end else begin
                        mem_write_enable <= 1'b0;
                        resp_rdata       <= 32'd0;
                        resp_fault       <= 1'b0;
                        resp_valid       <= 1'b1;
                        r_state          <= RESP;
                    end
                end
                WR2: begin
                    mem_write_enable <= 1'b0;
                    resp_rdata       <= 32'd0;
                    resp_fault       <= 1'b0;
                    resp_valid       <= 1'b1;
                    r_state          <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_read_data = 32'd0;
    logic [31:0] mem_read_address;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_write_mask;
    logic        mem_write_enable;

    load_store_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read_data(mem_read_data), .mem_read_address(mem_read_address),
        .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
        .mem_write_mask(mem_write_mask), .mem_write_enable(mem_write_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          acc;
        int          lat;
        bit          b2b;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] mask;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];
    int    cyc = 0;
    int    tests = 0;
    int    fails = 0;
    int    last_resp = 0;
    bit    chk_rst = 1'b0;
    bit    chk_ready = 1'b0;
    bit    chk_final = 1'b0;
    logic [31:0] mem [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_write_enable)
            mem[mem_write_address[5:2]] <= (mem[mem_write_address[5:2]] & ~mem_write_mask) |
                                          (mem_write_data & mem_write_mask);
        else
            mem_read_data <= mem[mem_read_address[5:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Single checking process: responses, memory writes and flagged spot checks.
    always @(negedge clk) begin
        resp_t e;
        wr_t   w;
        if (resp_valid) begin
            if (rq.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                e = rq.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.fault});
                chk("resp_latency", cyc - e.acc, e.lat);
                if (e.b2b) chk("b2b_accept", e.acc, last_resp + 2);
            end
            last_resp = cyc;
        end
        if (mem_write_enable) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", mem_write_address, 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                chk("wr_addr", mem_write_address, w.addr);
                chk("wr_mask", mem_write_mask, w.mask);
                chk("wr_data", mem_write_data, w.data);
                chk("wr_cycle", cyc, w.cyc);
            end
        end
        if (chk_rst) begin
            chk("rst_ready", {31'd0, req_ready}, 32'd0);
            chk("rst_resp", {30'd0, resp_valid, resp_fault}, 32'd0);
            chk("rst_rdata", resp_rdata, 32'd0);
            chk("rst_we", {31'd0, mem_write_enable}, 32'd0);
            chk("rst_raddr", mem_read_address, 32'd0);
            chk("rst_waddr", mem_write_address, 32'd0);
            chk("rst_wdata", mem_write_data, 32'd0);
            chk("rst_wmask", mem_write_mask, 32'd0);
        end
        if (chk_ready) chk("ready_after_release", {31'd0, req_ready}, 32'd1);
        if (chk_final) begin
            chk("resp_queue_drained", rq.size(), 32'd0);
            chk("write_queue_drained", wq.size(), 32'd0);
        end
    end

    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] er, input bit ef, input int lat, input bit b2b,
                         input bit track, input int nw, input wr_t w0, input wr_t w1);
        int n;
        wr_t a;
        wr_t b;
        n = 0;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            $display("FAIL accept_timeout: req_ready stuck at 0 for addr 0x%08h", addr);
            $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
            $fatal(1);
        end
        if (track) rq.push_back('{er, ef, cyc + 1, lat, b2b});
        if (nw > 0) begin a = w0; a.cyc = cyc + 1; wq.push_back(a); end
        if (nw > 1) begin b = w1; b.cyc = cyc + 2; wq.push_back(b); end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    wr_t nw0;

    initial begin
        nw0 = '{32'd0, 32'd0, 32'd0, 0};
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        @(posedge clk); #1 chk_rst = 1'b1;
        @(negedge clk); #1 chk_rst = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);

        // stores and loads on word 0x80000000
        issue(1, 2'd2, 0, 32'h8000_0000, 32'hDEAD_BEEF, 32'd0, 0, 1, 0, 1, 1,
              '{32'h8000_0000, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 0}, nw0);
        issue(0, 2'd2, 0, 32'h8000_0000, 32'd0, 32'hDEAD_BEEF, 0, 2, 1, 1, 0, nw0, nw0);
        issue(1, 2'd0, 0, 32'h8000_0002, 32'h0000_00AB, 32'd0, 0, 1, 1, 1, 1,
              '{32'h8000_0000, 32'h00FF_0000, 32'h00AB_0000, 0}, nw0);
        issue(0, 2'd0, 0, 32'h8000_0002, 32'd0, 32'hFFFF_FFAB, 0, 2, 1, 1, 0, nw0, nw0);
        issue(0, 2'd0, 1, 32'h8000_0002, 32'd0, 32'h0000_00AB, 0, 2, 1, 1, 0, nw0, nw0);
        issue(0, 2'd1, 0, 32'h8000_0002, 32'd0, 32'hFFFF_DEAB, 0, 2, 1, 1, 0, nw0, nw0);
        issue(0, 2'd1, 1, 32'h8000_0002, 32'd0, 32'h0000_DEAB, 0, 2, 1, 1, 0, nw0, nw0);
        issue(1, 2'd1, 0, 32'h8000_0000, 32'h0000_1234, 32'd0, 0, 1, 1, 1, 1,
              '{32'h8000_0000, 32'h0000_FFFF, 32'h0000_1234, 0}, nw0);
        issue(0, 2'd2, 1, 32'h8000_0000, 32'd0, 32'hDEAB_1234, 0, 2, 1, 1, 0, nw0, nw0);
        issue(0, 2'd0, 0, 32'h8000_0001, 32'd0, 32'h0000_0012, 0, 2, 1, 1, 0, nw0, nw0);
        issue(0, 2'd0, 0, 32'h8000_0003, 32'd0, 32'hFFFF_FFDE, 0, 2, 1, 1, 0, nw0, nw0);
        // illegal size always faults immediately
        issue(1, 2'd3, 0, 32'h8000_0000, 32'h1111_1111, 32'd0, 1, 0, 1, 1, 0, nw0, nw0);
        issue(0, 2'd3, 0, 32'h8000_0000, 32'd0, 32'd0, 1, 0, 1, 1, 0, nw0, nw0);
`ifdef LSU_MISALIGN_SPLIT_EN
        issue(1, 2'd2, 0, 32'h8000_0003, 32'h1122_3344, 32'd0, 0, 2, 1, 1, 2,
              '{32'h8000_0000, 32'hFF00_0000, 32'h4400_0000, 0},
              '{32'h8000_0004, 32'h00FF_FFFF, 32'h0011_2233, 0});
        issue(0, 2'd2, 0, 32'h8000_0003, 32'd0, 32'h1122_3344, 0, 3, 1, 1, 0, nw0, nw0);
        issue(0, 2'd1, 0, 32'h8000_0001, 32'd0, 32'hFFFF_AB12, 0, 2, 1, 1, 0, nw0, nw0);
        issue(0, 2'd1, 1, 32'h8000_0003, 32'd0, 32'h0000_3344, 0, 3, 1, 1, 0, nw0, nw0);
`else
        issue(0, 2'd1, 0, 32'h8000_0001, 32'd0, 32'd0, 1, 0, 1, 1, 0, nw0, nw0);
        issue(1, 2'd2, 0, 32'h8000_0002, 32'h5555_5555, 32'd0, 1, 0, 1, 1, 0, nw0, nw0);
        issue(0, 2'd2, 0, 32'h8000_0003, 32'd0, 32'd0, 1, 0, 1, 1, 0, nw0, nw0);
`endif
        // top of the address space
        issue(1, 2'd2, 0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 32'd0, 0, 1, 1, 1, 1,
              '{32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hCAFE_F00D, 0}, nw0);
        issue(0, 2'd2, 0, 32'hFFFF_FFFC, 32'd0, 32'hCAFE_F00D, 0, 2, 1, 1, 0, nw0, nw0);
`ifdef LSU_MISALIGN_SPLIT_EN
        issue(1, 2'd1, 0, 32'hFFFF_FFFF, 32'h0000_BEEF, 32'd0, 0, 2, 1, 1, 2,
              '{32'hFFFF_FFFC, 32'hFF00_0000, 32'hEF00_0000, 0},
              '{32'h0000_0000, 32'h0000_00FF, 32'h0000_00BE, 0});
        issue(0, 2'd1, 1, 32'hFFFF_FFFF, 32'd0, 32'h0000_BEEF, 0, 3, 1, 1, 0, nw0, nw0);
`endif
        // reset while the load sits in RD1: no response must follow
        issue(0, 2'd2, 0, 32'h8000_0000, 32'd0, 32'd0, 0, 2, 0, 0, 0, nw0, nw0);
        reset = 1'b0;
        @(posedge clk); #1 chk_rst = 1'b1;
        @(negedge clk); #1 chk_rst = 1'b0;
        @(posedge clk); #1 begin reset = 1'b1; chk_ready = 1'b1; end
        @(negedge clk); #1 chk_ready = 1'b0;
        issue(1, 2'd2, 0, 32'h8000_0008, 32'h5A5A_5A5A, 32'd0, 0, 1, 0, 1, 1,
              '{32'h8000_0008, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 0}, nw0);
        issue(0, 2'd2, 0, 32'h8000_0008, 32'd0, 32'h5A5A_5A5A, 0, 2, 1, 1, 0, nw0, nw0);

        for (int i = 0; i < 40 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 chk_final = 1'b1;
        @(negedge clk); #1 chk_final = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
